// File: rtl/tcl_pkg.sv
// Shared types and constants for the transaction-layer egress arbiter.
// Optional per-port word counters live in tcl_egress_arbiter (macro EGRESS_WORD_CNT_EN).
package tcl_pkg;

  localparam int unsigned DATA_W     = 12;
  localparam int unsigned NPORTS     = 4;
  localparam int unsigned PORT_W     = 2;
  localparam int unsigned SKID_DEPTH = 2;

  // Global state vector, one-hot
  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_CONFIG = 4'b0010,
    ST_ACTIVE = 4'b0100,
    ST_DRAIN  = 4'b1000
  } gstate_e;

  typedef struct packed {
    logic [PORT_W-1:0] port;
    logic [DATA_W-1:0] data;
  } egress_word_t;

  function automatic logic [PORT_W-1:0] onehot_to_idx(input logic [NPORTS-1:0] oh);
    logic [PORT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (oh[i]) idx = PORT_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tcl_egress_arbiter_if.sv
// Port-FIFO pop/data lines plus the ready/valid egress link of the arbiter.
interface tcl_egress_arbiter_if;
  import tcl_pkg::*;

  logic [NPORTS-1:0] empty;
  logic [DATA_W-1:0] data_p0;
  logic [DATA_W-1:0] data_p1;
  logic [DATA_W-1:0] data_p2;
  logic [DATA_W-1:0] data_p3;
  logic              pop_p0;
  logic              pop_p1;
  logic              pop_p2;
  logic              pop_p3;
  logic [DATA_W-1:0] out_data;
  logic [PORT_W-1:0] out_port;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  empty, data_p0, data_p1, data_p2, data_p3, out_ready,
    output pop_p0, pop_p1, pop_p2, pop_p3, out_data, out_port, out_valid
  );

  modport slave (
    output empty, data_p0, data_p1, data_p2, data_p3, out_ready,
    input  pop_p0, pop_p1, pop_p2, pop_p3, out_data, out_port, out_valid
  );

endinterface

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: first requester at or after ptr_i wins.
module rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [3:0] gnt_o,
  output logic       gnt_valid_o
);

  logic [1:0] idx;

  always_comb begin
    gnt_o = '0;
    idx   = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_i + 2'(k);
      if (req_i[idx] && (gnt_o == 4'b0000)) gnt_o[idx] = 1'b1;
    end
    gnt_valid_o = |req_i;
  end

endmodule

// File: rtl/tcl_egress_arbiter.sv
// Round-robin drain of four port FIFOs onto one tagged ready/valid link via a 2-entry skid.
// Define EGRESS_WORD_CNT_EN to add per-port saturating egress word counters.
module tcl_egress_arbiter
  import tcl_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [3:0]                state_i,
  tcl_egress_arbiter_if.master      bus,
  output logic                      idle_o
`ifdef EGRESS_WORD_CNT_EN
  ,
  input  logic [1:0]                cnt_sel_i,
  input  logic                      cnt_clr_i,
  output logic [7:0]                cnt_out_o
`endif
);

  logic [NPORTS-1:0] req, gnt, pop, pop_q;
  logic              gnt_valid, credit_ok, grant, hs, wr;
  logic [PORT_W-1:0] ptr_q, ptr_d, gnt_idx, tag_q;
  logic              inflight_q;
  logic [2:0]        occ;
  logic [DATA_W-1:0] data_sel;
  egress_word_t      skid_q [SKID_DEPTH];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        count_q, count_d;

  // A port popped last cycle may still show a stale non-empty flag
  assign req = ~bus.empty & ~pop_q & {NPORTS{state_i == ST_ACTIVE}};

  rr_pick4 u_pick (
    .req_i       (req),
    .ptr_i       (ptr_q),
    .gnt_o       (gnt),
    .gnt_valid_o (gnt_valid)
  );

  assign hs        = bus.out_valid && bus.out_ready;
  assign occ       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, hs};
  assign credit_ok = (occ < 3'(SKID_DEPTH));
  // Reset gates the combinational pop so no FIFO is drained while held in reset
  assign grant     = gnt_valid && credit_ok && rst_ni;
  assign pop       = grant ? gnt : '0;
  assign gnt_idx   = onehot_to_idx(gnt);
  assign ptr_d     = grant ? gnt_idx + 2'd1 : ptr_q;

  assign bus.pop_p0 = pop[0];
  assign bus.pop_p1 = pop[1];
  assign bus.pop_p2 = pop[2];
  assign bus.pop_p3 = pop[3];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pop_q      <= '0;
      ptr_q      <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      pop_q      <= pop;
      ptr_q      <= ptr_d;
      inflight_q <= grant;
      if (grant) tag_q <= gnt_idx;
    end
  end

  always_comb begin
    data_sel = '0;
    unique case (tag_q)
      2'd0: data_sel = bus.data_p0;
      2'd1: data_sel = bus.data_p1;
      2'd2: data_sel = bus.data_p2;
      2'd3: data_sel = bus.data_p3;
    endcase
  end

  // In-flight data always lands, whatever the global state has become
  assign wr      = inflight_q;
  assign count_d = count_q + {1'b0, wr} - {1'b0, hs};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SKID_DEPTH; i++) skid_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (wr) begin
        skid_q[wr_ptr_q] <= '{port: tag_q, data: data_sel};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (hs) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_data  = skid_q[rd_ptr_q].data;
  assign bus.out_port  = skid_q[rd_ptr_q].port;
  assign idle_o        = (count_q == 2'd0) && !inflight_q && !grant;

`ifdef EGRESS_WORD_CNT_EN
  logic [7:0] cnt_q [NPORTS];
  logic [7:0] cnt_out_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NPORTS; i++) cnt_q[i] <= '0;
      cnt_out_q <= '0;
    end else begin
      if (cnt_clr_i) begin
        for (int i = 0; i < NPORTS; i++) cnt_q[i] <= '0;
      end else if (hs && (cnt_q[bus.out_port] != 8'hff)) begin
        cnt_q[bus.out_port] <= cnt_q[bus.out_port] + 8'd1;
      end
      cnt_out_q <= cnt_clr_i ? 8'd0 : cnt_q[cnt_sel_i];
    end
  end

  assign cnt_out_o = cnt_out_q;
`endif

endmodule

// File: tb/tb_tcl_egress_arbiter.sv
// Self-checking bench: behavioural port FIFOs feed the arbiter, egress is scoreboarded.
module tb_tcl_egress_arbiter;
  import tcl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] state;
  logic       idle;
  int         total = 0;
  int         bad = 0;
  int         pop_total = 0;
  int         viol = 0;

  logic [11:0] fq [4][$];
  logic [13:0] exp_q [$];
  logic [3:0]  pops;
  logic [3:0]  pop_prev = '0;
  logic [3:0]  nxt_empty;
  logic [11:0] mw;

  always #5 clk = ~clk;

  tcl_egress_arbiter_if bus ();

`ifdef EGRESS_WORD_CNT_EN
  logic [1:0] cnt_sel;
  logic       cnt_clr;
  logic [7:0] cnt_out;
`endif

  tcl_egress_arbiter dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .state_i   (state),
    .bus       (bus),
    .idle_o    (idle)
`ifdef EGRESS_WORD_CNT_EN
    ,
    .cnt_sel_i (cnt_sel),
    .cnt_clr_i (cnt_clr),
    .cnt_out_o (cnt_out)
`endif
  );

  assign pops = {bus.pop_p3, bus.pop_p2, bus.pop_p1, bus.pop_p0};

  // Port FIFO model: registered read data, one-cycle read latency
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pops[i]) begin
        pop_total++;
        if (fq[i].size() == 0) viol++;
        else begin
          mw = fq[i].pop_front();
          case (i)
            0: bus.data_p0 <= mw;
            1: bus.data_p1 <= mw;
            2: bus.data_p2 <= mw;
            default: bus.data_p3 <= mw;
          endcase
        end
      end
    end
    if ($countones(pops) > 1) viol++;
    if ((pops & pop_prev) != 4'b0000) viol++;
    pop_prev = pops;
    for (int i = 0; i < 4; i++) nxt_empty[i] = (fq[i].size() == 0);
    bus.empty <= nxt_empty;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    state = ST_IDLE;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) fq[i].delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    state = ST_ACTIVE;
    bus.out_ready = 1'b1;
    fq[0].push_back(12'h5a5);
    repeat (3) @(negedge clk);
    total++; if (pops !== 4'b0000) begin bad++; $display("FAIL reset_pop: got %b want 0000", pops); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_data !== 12'h000) begin bad++; $display("FAIL reset_data: got %h want 000", bus.out_data); end
    total++; if (bus.out_port !== 2'd0) begin bad++; $display("FAIL reset_port: got %0d want 0", bus.out_port); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle: got %b want 1", idle); end
  endtask

  task automatic test_round_robin();
    int cyc = 0, fp = -1, fv = -1, fh = -1, lh = -1;
    logic [11:0] w;
    logic [13:0] e;
    do_reset();
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 4; i++) begin
        w = 12'(i * 256 + 16 + j);
        fq[i].push_back(w);
        exp_q.push_back({2'(i), w});
      end
    @(negedge clk);
    state = ST_ACTIVE;
    repeat (40) begin
      #1;
      if (pops != 4'b0000 && fp < 0) fp = cyc;
      if (bus.out_valid && fv < 0) fv = cyc;
      if (bus.out_valid && bus.out_ready) begin
        if (fh < 0) fh = cyc;
        lh = cyc;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rr_extra: got %h want none", {bus.out_port, bus.out_data});
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_port, bus.out_data} !== e) begin
            bad++; $display("FAIL rr_word: got %h want %h", {bus.out_port, bus.out_data}, e);
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    total++; if (fv - fp !== 2) begin bad++; $display("FAIL rr_latency: got %0d want 2", fv - fp); end
    total++; if (lh - fh !== 7) begin bad++; $display("FAIL rr_rate: got %0d want 7", lh - fh); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL rr_missing: got %0d want 0", exp_q.size()); end
    total++; if (viol !== 0) begin bad++; $display("FAIL rr_pop_rules: got %0d want 0", viol); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL rr_idle: got %b want 1", idle); end
  endtask

  task automatic test_single_port();
    int cyc = 0, prev = -1, gap_bad = 0, p0;
    logic [13:0] e;
    do_reset();
    for (int j = 0; j < 3; j++) begin
      fq[2].push_back(12'(12'h200 + j));
      exp_q.push_back({2'd2, 12'(12'h200 + j)});
    end
    @(negedge clk);
    p0 = pop_total;
    state = ST_ACTIVE;
    repeat (20) begin
      #1;
      if (pops != 4'b0000) begin
        if (pops != 4'b0100) gap_bad++;
        if (prev >= 0 && cyc - prev != 2) gap_bad++;
        prev = cyc;
      end
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL single_extra: got %h want none", {bus.out_port, bus.out_data});
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_port, bus.out_data} !== e) begin
            bad++; $display("FAIL single_word: got %h want %h", {bus.out_port, bus.out_data}, e);
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    total++; if (gap_bad !== 0) begin bad++; $display("FAIL single_alternate: got %0d want 0", gap_bad); end
    total++; if (pop_total - p0 !== 3) begin bad++; $display("FAIL single_pops: got %0d want 3", pop_total - p0); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL single_missing: got %0d want 0", exp_q.size()); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL single_idle: got %b want 1", idle); end
  endtask

  task automatic test_stall();
    int p0, chg = 0, gaps = 0, started = 0;
    logic [13:0] held = '0, e;
    logic held_set = 1'b0;
    do_reset();
    bus.out_ready = 1'b0;
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < 4; i++) begin
        fq[i].push_back(12'(i * 256 + 12'h40 + j));
        exp_q.push_back({2'(i), 12'(i * 256 + 12'h40 + j)});
      end
    @(negedge clk);
    p0 = pop_total;
    state = ST_ACTIVE;
    repeat (12) begin
      #1;
      if (bus.out_valid) begin
        if (held_set && {bus.out_port, bus.out_data} !== held) chg++;
        held = {bus.out_port, bus.out_data};
        held_set = 1'b1;
      end
      @(negedge clk);
    end
    total++; if (pop_total - p0 !== 2) begin bad++; $display("FAIL stall_pops: got %0d want 2", pop_total - p0); end
    total++; if (chg !== 0) begin bad++; $display("FAIL stall_hold: got %0d changes want 0", chg); end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid: got %b want 1", bus.out_valid); end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 80 && exp_q.size() != 0; c++) begin
      #1;
      if (bus.out_valid && bus.out_ready) begin
        started = 1;
        total++;
        e = exp_q.pop_front();
        if ({bus.out_port, bus.out_data} !== e) begin
          bad++; $display("FAIL stall_word: got %h want %h", {bus.out_port, bus.out_data}, e);
        end
      end else if (started != 0) gaps++;
      @(negedge clk);
    end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL stall_missing: got %0d want 0", exp_q.size()); end
    total++; if (gaps !== 0) begin bad++; $display("FAIL stall_rate: got %0d bubbles want 0", gaps); end
    total++; if (pop_total - p0 !== 32) begin bad++; $display("FAIL stall_total: got %0d want 32", pop_total - p0); end
    total++; if (viol !== 0) begin bad++; $display("FAIL stall_pop_rules: got %0d want 0", viol); end
  endtask

  task automatic test_leave_active();
    int p0, n = 0, seen = 0;
    logic [13:0] e;
    do_reset();
    for (int j = 0; j < 3; j++) begin
      fq[0].push_back(12'(12'h300 + j));
      exp_q.push_back({2'd0, 12'(12'h300 + j)});
    end
    @(negedge clk);
    state = ST_ACTIVE;
    for (int c = 0; c < 6 && seen == 0; c++) begin
      #1;
      if (pops != 4'b0000) seen = 1;
      else @(negedge clk);
    end
    total++; if (seen !== 1) begin bad++; $display("FAIL leave_first_pop: got %0d want 1", seen); end
    @(posedge clk);
    #1;
    state = ST_DRAIN;
    p0 = pop_total;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        n++;
        total++;
        e = exp_q.pop_front();
        if ({bus.out_port, bus.out_data} !== e) begin
          bad++; $display("FAIL leave_word: got %h want %h", {bus.out_port, bus.out_data}, e);
        end
      end
    end
    total++; if (n !== 1) begin bad++; $display("FAIL leave_delivered: got %0d want 1", n); end
    total++; if (pop_total - p0 !== 0) begin bad++; $display("FAIL leave_pops: got %0d want 0", pop_total - p0); end
    @(negedge clk);
    state = ST_ACTIVE;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      #1;
      if (bus.out_valid && bus.out_ready) begin
        total++;
        e = exp_q.pop_front();
        if ({bus.out_port, bus.out_data} !== e) begin
          bad++; $display("FAIL leave_resume: got %h want %h", {bus.out_port, bus.out_data}, e);
        end
      end
      @(negedge clk);
    end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL leave_missing: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) fq[i].push_back(12'(i * 256 + 12'h80 + j));
    @(negedge clk);
    state = ST_ACTIVE;
    repeat (6) @(negedge clk);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL areset_full: got %b want 1", bus.out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL areset_valid: got %b want 0", bus.out_valid); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL areset_idle: got %b want 1", idle); end
    fq[0].delete();
    state = ST_IDLE;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    state = ST_ACTIVE;
    #1;
    total++; if (pops !== 4'b0010) begin bad++; $display("FAIL areset_first_grant: got %b want 0010", pops); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL areset_discard: got %b want 0", bus.out_valid); end
  endtask

`ifdef EGRESS_WORD_CNT_EN
  task automatic test_word_cnt();
    logic [13:0] e;
    do_reset();
    cnt_sel = 2'd1;
    for (int j = 0; j < 300; j++) begin
      fq[1].push_back(12'(j));
      exp_q.push_back({2'd1, 12'(j)});
    end
    @(negedge clk);
    state = ST_ACTIVE;
    for (int c = 0; c < 800 && exp_q.size() != 0; c++) begin
      #1;
      if (bus.out_valid && bus.out_ready) begin
        total++;
        e = exp_q.pop_front();
        if ({bus.out_port, bus.out_data} !== e) begin
          bad++; $display("FAIL cnt_word: got %h want %h", {bus.out_port, bus.out_data}, e);
        end
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    total++; if (cnt_out !== 8'd255) begin bad++; $display("FAIL cnt_sat: got %0d want 255", cnt_out); end
    cnt_sel = 2'd0;
    repeat (2) @(negedge clk);
    total++; if (cnt_out !== 8'd0) begin bad++; $display("FAIL cnt_other: got %0d want 0", cnt_out); end
    cnt_sel = 2'd1;
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    total++; if (cnt_out !== 8'd0) begin bad++; $display("FAIL cnt_clr: got %0d want 0", cnt_out); end
    @(negedge clk);
    total++; if (cnt_out !== 8'd0) begin bad++; $display("FAIL cnt_clr_hold: got %0d want 0", cnt_out); end
  endtask
`endif

  initial begin
`ifdef EGRESS_WORD_CNT_EN
    cnt_sel = 2'd0;
    cnt_clr = 1'b0;
`endif
    test_reset();
    test_round_robin();
    test_single_port();
    test_stall();
    test_leave_active();
    test_async_reset();
`ifdef EGRESS_WORD_CNT_EN
    test_word_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
